// File: rtl/pwm_fader.sv
// Multi-channel PWM generator with a shared prescaler/period counter and per-channel
// duty ramping; duty changes are applied only on period wrap so outputs never glitch.
module pwm_fader #(
    parameter int CHANNELS      = 2,
    parameter int BITS          = 10,
    parameter int MAX_VALUE     = 1000,
    parameter int PRESCALE      = 250,
    parameter int PRESCALE_BITS = 8,
    parameter int RAMP_STEP     = 8,
    parameter int RAMP_DIVIDE   = 1,
    parameter int RESET_VALUE   = MAX_VALUE
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [CHANNELS*BITS-1:0] target,
    input  logic [CHANNELS-1:0]      load,
    input  logic                     immediate,
    output logic [CHANNELS-1:0]      signal,
    output logic [CHANNELS*BITS-1:0] current,
    output logic [CHANNELS-1:0]      ramping,
    output logic                     period_start
);

    localparam int DIV_BITS = (RAMP_DIVIDE > 1) ? $clog2(RAMP_DIVIDE) : 1;

    localparam logic [BITS-1:0]          MAX_V       = BITS'(MAX_VALUE);
    localparam logic [BITS-1:0]          RESET_V     = BITS'(RESET_VALUE);
    localparam logic [BITS-1:0]          PERIOD_LAST = BITS'(MAX_VALUE - 1);
    localparam logic [BITS:0]            STEP_W      = (BITS + 1)'(RAMP_STEP);
    localparam logic [PRESCALE_BITS-1:0] PRESC_LAST  = PRESCALE_BITS'(PRESCALE - 1);
    localparam logic [DIV_BITS-1:0]      DIV_LAST    = DIV_BITS'(RAMP_DIVIDE - 1);

    // Limit a requested duty to the period length.
    function automatic logic [BITS-1:0] clamp_target(input logic [BITS-1:0] value);
        if (value > MAX_V) begin
            return MAX_V;
        end else begin
            return value;
        end
    endfunction

    // One fade step toward the target; widened by one bit so neither direction wraps.
    function automatic logic [BITS-1:0] ramp_next(input logic [BITS-1:0] cur,
                                                  input logic [BITS-1:0] tgt);
        logic [BITS:0] cur_w;
        logic [BITS:0] tgt_w;
        logic [BITS:0] sum_w;
        logic [BITS:0] lim_w;
        logic [BITS:0] diff_w;
        cur_w  = {1'b0, cur};
        tgt_w  = {1'b0, tgt};
        sum_w  = cur_w + STEP_W;
        lim_w  = tgt_w + STEP_W;
        diff_w = cur_w - STEP_W;
        if (cur_w < tgt_w) begin
            if (sum_w > tgt_w) begin
                return tgt;
            end else begin
                return sum_w[BITS-1:0];
            end
        end else if (cur_w > tgt_w) begin
            if (cur_w > lim_w) begin
                return diff_w[BITS-1:0];
            end else begin
                return tgt;
            end
        end else begin
            return cur;
        end
    endfunction

    logic [PRESCALE_BITS-1:0] presc_r;
    logic [BITS-1:0]          period_r;
    logic [DIV_BITS-1:0]      div_r;
    logic                     tick_s;
    logic                     wrap_s;
    logic                     step_s;

    // Tick, period wrap and ramp-step qualifiers derived from the shared counters.
    always_comb begin
        tick_s = enable && (presc_r == PRESC_LAST);
        wrap_s = tick_s && (period_r == PERIOD_LAST);
        step_s = (div_r == DIV_LAST);
    end

    // Shared prescaler, period counter, ramp divider and period_start pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            presc_r      <= '0;
            period_r     <= '0;
            div_r        <= '0;
            period_start <= 1'b0;
        end else if (!enable) begin
            presc_r      <= '0;
            period_r     <= '0;
            div_r        <= '0;
            period_start <= 1'b0;
        end else begin
            if (tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PRESCALE_BITS'(1);
            end
            if (wrap_s) begin
                period_r <= '0;
            end else if (tick_s) begin
                period_r <= period_r + BITS'(1);
            end else begin
                period_r <= period_r;
            end
            if (wrap_s) begin
                if (step_s) begin
                    div_r <= '0;
                end else begin
                    div_r <= div_r + DIV_BITS'(1);
                end
            end else begin
                div_r <= div_r;
            end
            period_start <= wrap_s;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [BITS-1:0] field_s;
        logic [BITS-1:0] next_cur_s;
        logic [BITS-1:0] target_r;
        logic [BITS-1:0] current_r;
        logic            imm_r;
        logic            signal_r;
        logic            ramping_r;

        assign field_s = target[i*BITS +: BITS];

        // Duty to adopt at the next wrap: jump, fade step, or hold.
        always_comb begin
            next_cur_s = current_r;
            if (imm_r) begin
                next_cur_s = target_r;
            end else if (step_s) begin
                next_cur_s = ramp_next(current_r, target_r);
            end else begin
                next_cur_s = current_r;
            end
        end

        // Channel state; a load coincident with a wrap lands after that wrap's update.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                target_r  <= RESET_V;
                current_r <= RESET_V;
                imm_r     <= 1'b0;
                signal_r  <= 1'b0;
                ramping_r <= 1'b0;
            end else begin
                if (load[i]) begin
                    target_r <= clamp_target(field_s);
                    imm_r    <= immediate;
                end else if (wrap_s) begin
                    imm_r <= 1'b0;
                end else begin
                    imm_r <= imm_r;
                end
                if (wrap_s) begin
                    current_r <= next_cur_s;
                end else begin
                    current_r <= current_r;
                end
                signal_r  <= enable && (period_r < current_r);
                ramping_r <= (current_r != target_r);
            end
        end

        assign signal[i]              = signal_r;
        assign ramping[i]             = ramping_r;
        assign current[i*BITS +: BITS] = current_r;
    end

endmodule
